// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- MEM pipeline stage with a stalling data-memory handshake.
//
// Purpose:
//    Passes ALU results to the MEM/WB register in one cycle. A load or store
//    is latched into holding registers and issued as a req/ack transaction.
//    Upstream stages are frozen via o_mem_stall until the access completes or
//    times out.
//
// Optional feature macro: MEM_SUBWORD_EN
//    When defined, byte and halfword loads and stores are supported (i_func).
//    Misaligned halfword or word accesses raise o_mem_fault.
//    When undefined, every access is a full word and i_func is ignored.
//
// Parameters:
//    TIMEOUT_CYCLES  max ACCESS cycles waiting for ack (0 = never time out)
//
// Ports:
//    i_clk, i_rst                 clock, async active-high reset
//    i_result                     ALU result / byte address
//    i_data_for_writing_for_sw    store data
//    i_mem_enable_mem, i_mem_read_mem, i_mem_write_mem,
//    i_wb_enable_mem, i_ld_mem    EX/MEM control bits
//    i_rd_mem                     destination register
//    i_func                       load/store width code
//    o_dmem_req, o_dmem_we        memory request / write select
//    o_dmem_addr, o_dmem_wdata,
//    o_dmem_wstrb                 word address, write data, byte strobes
//    i_dmem_ack, i_dmem_rdata     completion and read data
//    o_mem_stall                  freeze request to upstream stages
//    o_wb_data, o_rd_wb,
//    o_wb_enable_wb               MEM/WB pipeline register
//    o_mem_fault                  one-cycle pulse on timeout / misalignment
// ---------------------------------------------------------------------------
module mem_stage #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_result,
   input  logic [31:0] i_data_for_writing_for_sw,
   input  logic        i_mem_enable_mem,
   input  logic        i_mem_read_mem,
   input  logic        i_mem_write_mem,
   input  logic        i_wb_enable_mem,
   input  logic        i_ld_mem,
   input  logic [4:0]  i_rd_mem,
   input  logic [2:0]  i_func,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [31:0] o_dmem_wdata,
   output logic [3:0]  o_dmem_wstrb,
   input  logic        i_dmem_ack,
   input  logic [31:0] i_dmem_rdata,
   output logic        o_mem_stall,
   output logic [31:0] o_wb_data,
   output logic [4:0]  o_rd_wb,
   output logic        o_wb_enable_wb,
   output logic        o_mem_fault
);

   typedef enum logic {IDLE, ACCESS} state_t;

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [3:0]    r_wstrb;
   logic          r_we;
   logic [4:0]    r_rd;
   logic          r_wb_en_hold;
   logic [31:0]   r_wb_data;
   logic [4:0]    r_rd_wb;
   logic          r_wb_en;
   logic          r_fault;

   logic          w_start;
   logic          w_misaligned;
   logic [31:0]   w_cap_wdata;
   logic [3:0]    w_cap_wstrb;
   logic [31:0]   w_load_data;
   logic          w_unused;

`ifdef MEM_SUBWORD_EN
   logic [1:0]    r_off;
   logic [2:0]    r_func;
   logic [31:0]   w_shifted;
`endif

   assign w_start      = (r_state == IDLE) && i_mem_enable_mem
                         && (i_mem_read_mem || i_mem_write_mem);
   // Reset gating keeps the stall low while rst is held, even if a start pattern is present
   assign o_mem_stall  = !i_rst && (w_start || (r_state == ACCESS));
   assign o_dmem_req   = (r_state == ACCESS);
   assign o_dmem_we    = (r_state == ACCESS) && r_we;
   assign o_dmem_addr  = r_addr;
   assign o_dmem_wdata = r_wdata;
   assign o_dmem_wstrb = r_wstrb;
   assign o_wb_data    = r_wb_data;
   assign o_rd_wb      = r_rd_wb;
   assign o_wb_enable_wb = r_wb_en;
   assign o_mem_fault  = r_fault;

   // Store lane placement and alignment check for the access being started
   always_comb begin
      w_cap_wdata  = i_data_for_writing_for_sw;
      w_cap_wstrb  = 4'hF;
      w_misaligned = 1'b0;
`ifdef MEM_SUBWORD_EN
      case (i_func[1:0])
         2'b00: begin
            w_cap_wdata = {4{i_data_for_writing_for_sw[7:0]}};
            w_cap_wstrb = 4'b0001 << i_result[1:0];
         end
         2'b01: begin
            w_cap_wdata  = {2{i_data_for_writing_for_sw[15:0]}};
            w_cap_wstrb  = i_result[1] ? 4'b1100 : 4'b0011;
            w_misaligned = i_result[0];
         end
         default: w_misaligned = |i_result[1:0];
      endcase
`endif
   end

   // Load data formatting: lane extraction plus sign/zero extension
`ifdef MEM_SUBWORD_EN
   assign w_shifted = i_dmem_rdata >> {r_off, 3'b000};
   always_comb begin
      case (r_func)
         3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b100:  w_load_data = {24'b0, w_shifted[7:0]};
         3'b101:  w_load_data = {16'b0, w_shifted[15:0]};
         default: w_load_data = i_dmem_rdata;
      endcase
   end
   assign w_unused = ^{i_ld_mem, w_shifted[31:16]};
`else
   assign w_load_data = i_dmem_rdata;
   assign w_unused = ^{i_ld_mem, i_func, i_result[1:0]};
`endif

   // Access FSM, holding registers and MEM/WB register. Once in ACCESS only
   // the holding registers are used, so upstream bubbles cannot disturb it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_wstrb      <= '0;
         r_we         <= 1'b0;
         r_rd         <= '0;
         r_wb_en_hold <= 1'b0;
         r_wb_data    <= '0;
         r_rd_wb      <= '0;
         r_wb_en      <= 1'b0;
         r_fault      <= 1'b0;
`ifdef MEM_SUBWORD_EN
         r_off        <= '0;
         r_func       <= '0;
`endif
      end else begin
         r_fault <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_wb_en <= 1'b0;
                  if (w_misaligned) begin
                     r_fault <= 1'b1;
                  end else begin
                     r_addr       <= {i_result[31:2], 2'b00};
                     r_wdata      <= w_cap_wdata;
                     r_wstrb      <= w_cap_wstrb;
                     r_we         <= i_mem_write_mem;
                     r_rd         <= i_rd_mem;
                     r_wb_en_hold <= i_wb_enable_mem;
                     r_cnt        <= '0;
                     r_state      <= ACCESS;
`ifdef MEM_SUBWORD_EN
                     r_off        <= i_result[1:0];
                     r_func       <= i_func;
`endif
                  end
               end else begin
                  r_wb_data <= i_result;
                  r_rd_wb   <= i_rd_mem;
                  r_wb_en   <= i_wb_enable_mem;
               end
            end
            ACCESS: begin
               if (i_dmem_ack) begin
                  r_rd_wb <= r_rd;
                  r_state <= IDLE;
                  if (r_we) begin
                     r_wb_en <= 1'b0;
                  end else begin
                     r_wb_data <= w_load_data;
                     r_wb_en   <= r_wb_en_hold;
                  end
               end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == LAST_CNT)) begin
                  r_wb_en <= 1'b0;
                  r_fault <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_wb_en <= 1'b0;
                  r_cnt   <= r_cnt + CW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- directed self-checking bench for mem_stage.
// DUT is built with TIMEOUT_CYCLES=4. Subword scenarios are compiled only
// when MEM_SUBWORD_EN is defined, otherwise the word-only behaviour is checked.
// ---------------------------------------------------------------------------
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] result;
   logic [31:0] storeData;
   logic        memEnable, memRead, memWrite, wbEnable, ldMem;
   logic [4:0]  rdMem;
   logic [2:0]  func;
   logic        dmemReq, dmemWe;
   logic [31:0] dmemAddr, dmemWdata;
   logic [3:0]  dmemWstrb;
   logic        dmemAck;
   logic [31:0] dmemRdata;
   logic        memStall;
   logic [31:0] wbData;
   logic [4:0]  rdWb;
   logic        wbEnableWb;
   logic        memFault;

   int assertCount = 0;
   int failCount = 0;

   mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_result(result),
      .i_data_for_writing_for_sw(storeData),
      .i_mem_enable_mem(memEnable), .i_mem_read_mem(memRead),
      .i_mem_write_mem(memWrite), .i_wb_enable_mem(wbEnable),
      .i_ld_mem(ldMem), .i_rd_mem(rdMem), .i_func(func),
      .o_dmem_req(dmemReq), .o_dmem_we(dmemWe), .o_dmem_addr(dmemAddr),
      .o_dmem_wdata(dmemWdata), .o_dmem_wstrb(dmemWstrb),
      .i_dmem_ack(dmemAck), .i_dmem_rdata(dmemRdata),
      .o_mem_stall(memStall), .o_wb_data(wbData), .o_rd_wb(rdWb),
      .o_wb_enable_wb(wbEnableWb), .o_mem_fault(memFault)
   );

   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one EX/MEM instruction; the #1 lets combinational outputs settle
   task automatic applyStimulus(input logic memEn, input logic rdEn, input logic wrEn,
                                input logic wbEn, input logic [4:0] rd,
                                input logic [31:0] res, input logic [31:0] wdata,
                                input logic [2:0] fn);
      memEnable = memEn;
      memRead   = rdEn;
      ldMem     = rdEn;
      memWrite  = wrEn;
      wbEnable  = wbEn;
      rdMem     = rd;
      result    = res;
      storeData = wdata;
      func      = fn;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      dmemAck = 1'b0;
      dmemRdata = 32'h0;
      applyStimulus(1, 1, 0, 1, 5'd3, 32'h0000_0100, 32'h0, 3'b010);
      tick();
      if (memStall !== 1'b0) begin $display("[TB] FAIL reset_stall: got %b expected 0", memStall); failCount++; end
      assertCount++;
      if (dmemReq !== 1'b0 || dmemWe !== 1'b0) begin $display("[TB] FAIL reset_req_we: got %b%b expected 00", dmemReq, dmemWe); failCount++; end
      assertCount++;
      if (dmemAddr !== 32'h0 || dmemWdata !== 32'h0 || dmemWstrb !== 4'h0) begin
         $display("[TB] FAIL reset_dmem_bus: got %h %h %h expected zeros", dmemAddr, dmemWdata, dmemWstrb); failCount++; end
      assertCount++;
      if (wbData !== 32'h0 || rdWb !== 5'd0 || wbEnableWb !== 1'b0 || memFault !== 1'b0) begin
         $display("[TB] FAIL reset_memwb: got %h %0d %b %b expected zeros", wbData, rdWb, wbEnableWb, memFault); failCount++; end
      assertCount++;
      applyStimulus(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 3'b010);
      rst = 1'b0;
   endtask

   task automatic test_alu_passthrough();
      applyStimulus(0, 0, 0, 1, 5'd7, 32'h0000_0055, 32'h0, 3'b010);
      if (memStall !== 1'b0) begin $display("[TB] FAIL alu_stall_pre: got %b expected 0", memStall); failCount++; end
      assertCount++;
      tick();
      if (wbData !== 32'h55 || rdWb !== 5'd7 || wbEnableWb !== 1'b1) begin
         $display("[TB] FAIL alu_memwb: got %h %0d %b expected 00000055 7 1", wbData, rdWb, wbEnableWb); failCount++; end
      assertCount++;
      if (memStall !== 1'b0 || dmemReq !== 1'b0) begin $display("[TB] FAIL alu_stall_post: got %b req %b expected 0 0", memStall, dmemReq); failCount++; end
      assertCount++;
      applyStimulus(0, 0, 0, 0, 5'd31, 32'hA5A5_0001, 32'h0, 3'b010);
      tick();
      if (wbData !== 32'hA5A5_0001 || rdWb !== 5'd31 || wbEnableWb !== 1'b0) begin
         $display("[TB] FAIL alu_memwb2: got %h %0d %b expected a5a50001 31 0", wbData, rdWb, wbEnableWb); failCount++; end
      assertCount++;
   endtask

   task automatic test_load_wait();
      int stallCycles = 0;
      applyStimulus(1, 1, 0, 1, 5'd5, 32'h0000_0100, 32'h0, 3'b010);
      if (memStall !== 1'b1 || dmemReq !== 1'b0) begin $display("[TB] FAIL load_start: got stall %b req %b expected 1 0", memStall, dmemReq); failCount++; end
      assertCount++;
      stallCycles++;
      tick();
      applyStimulus(0, 0, 0, 0, 5'd0, 32'hFFFF_FFFC, 32'h0, 3'b010);
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin dmemAck = 1'b1; dmemRdata = 32'hDEAD_BEEF; #1; end
         if (dmemReq !== 1'b1 || dmemWe !== 1'b0 || dmemAddr !== 32'h100 || wbEnableWb !== 1'b0) begin
            $display("[TB] FAIL load_access: cycle %0d got req %b we %b addr %h wben %b expected 1 0 00000100 0", i, dmemReq, dmemWe, dmemAddr, wbEnableWb); failCount++; end
         assertCount++;
         if (memStall === 1'b1) stallCycles++;
         tick();
      end
      dmemAck = 1'b0;
      dmemRdata = 32'h0;
      #1;
      if (stallCycles !== 4) begin $display("[TB] FAIL load_stall_len: got %0d expected 4", stallCycles); failCount++; end
      assertCount++;
      if (wbData !== 32'hDEAD_BEEF || wbEnableWb !== 1'b1 || rdWb !== 5'd5) begin
         $display("[TB] FAIL load_result: got %h %b %0d expected deadbeef 1 5", wbData, wbEnableWb, rdWb); failCount++; end
      assertCount++;
      if (memStall !== 1'b0 || dmemReq !== 1'b0) begin $display("[TB] FAIL load_release: got stall %b req %b expected 0 0", memStall, dmemReq); failCount++; end
      assertCount++;
      tick();
      if (wbEnableWb !== 1'b0) begin $display("[TB] FAIL load_wben_pulse: got %b expected 0", wbEnableWb); failCount++; end
      assertCount++;
   endtask

   task automatic test_store();
      applyStimulus(1, 0, 1, 1, 5'd9, 32'h0000_0200, 32'h1234_5678, 3'b010);
      tick();
      applyStimulus(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 3'b010);
      dmemAck = 1'b1;
      #1;
      if (dmemReq !== 1'b1 || dmemWe !== 1'b1 || dmemAddr !== 32'h200 || dmemWdata !== 32'h1234_5678 || dmemWstrb !== 4'hF) begin
         $display("[TB] FAIL store_bus: got req %b we %b addr %h data %h strb %h expected 1 1 00000200 12345678 f", dmemReq, dmemWe, dmemAddr, dmemWdata, dmemWstrb); failCount++; end
      assertCount++;
      tick();
      dmemAck = 1'b0;
      #1;
      if (wbEnableWb !== 1'b0 || memStall !== 1'b0 || dmemReq !== 1'b0 || dmemWe !== 1'b0) begin
         $display("[TB] FAIL store_done: got wben %b stall %b req %b we %b expected 0 0 0 0", wbEnableWb, memStall, dmemReq, dmemWe); failCount++; end
      assertCount++;
   endtask

   task automatic test_timeout();
      applyStimulus(1, 1, 0, 1, 5'd3, 32'h0000_0300, 32'h0, 3'b010);
      tick();
      applyStimulus(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 3'b010);
      for (int i = 0; i < 4; i++) begin
         if (dmemReq !== 1'b1 || memFault !== 1'b0 || memStall !== 1'b1) begin
            $display("[TB] FAIL timeout_wait: cycle %0d got req %b fault %b stall %b expected 1 0 1", i, dmemReq, memFault, memStall); failCount++; end
         assertCount++;
         tick();
      end
      if (dmemReq !== 1'b0 || memFault !== 1'b1 || memStall !== 1'b0 || wbEnableWb !== 1'b0) begin
         $display("[TB] FAIL timeout_fire: got req %b fault %b stall %b wben %b expected 0 1 0 0", dmemReq, memFault, memStall, wbEnableWb); failCount++; end
      assertCount++;
      // Stray ack while idle must not disturb the pass-through path
      dmemAck = 1'b1;
      dmemRdata = 32'hCAFE_F00D;
      applyStimulus(0, 0, 0, 1, 5'd4, 32'h0000_0011, 32'h0, 3'b010);
      tick();
      dmemAck = 1'b0;
      if (memFault !== 1'b0) begin $display("[TB] FAIL timeout_pulse: got %b expected 0", memFault); failCount++; end
      assertCount++;
      if (wbData !== 32'h11 || rdWb !== 5'd4 || dmemReq !== 1'b0) begin
         $display("[TB] FAIL idle_ack_ignored: got %h %0d req %b expected 00000011 4 0", wbData, rdWb, dmemReq); failCount++; end
      assertCount++;
   endtask

   task automatic test_back_to_back();
      applyStimulus(1, 1, 0, 1, 5'd2, 32'h0000_0040, 32'h0, 3'b010);
      tick();
      // Next instruction (a store) waits in EX/MEM while the load completes
      applyStimulus(1, 0, 1, 0, 5'd0, 32'h0000_0080, 32'hAAAA_5555, 3'b010);
      dmemAck = 1'b1;
      dmemRdata = 32'h0102_0304;
      #1;
      if (dmemAddr !== 32'h40 || dmemWe !== 1'b0 || memStall !== 1'b1) begin
         $display("[TB] FAIL b2b_hold: got addr %h we %b stall %b expected 00000040 0 1", dmemAddr, dmemWe, memStall); failCount++; end
      assertCount++;
      tick();
      dmemAck = 1'b0;
      #1;
      if (wbData !== 32'h0102_0304 || wbEnableWb !== 1'b1 || rdWb !== 5'd2) begin
         $display("[TB] FAIL b2b_load_result: got %h %b %0d expected 01020304 1 2", wbData, wbEnableWb, rdWb); failCount++; end
      assertCount++;
      if (dmemReq !== 1'b0 || memStall !== 1'b1) begin $display("[TB] FAIL b2b_gap: got req %b stall %b expected 0 1", dmemReq, memStall); failCount++; end
      assertCount++;
      tick();
      applyStimulus(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 3'b010);
      if (dmemReq !== 1'b1 || dmemWe !== 1'b1 || dmemAddr !== 32'h80 || dmemWdata !== 32'hAAAA_5555) begin
         $display("[TB] FAIL b2b_store: got req %b we %b addr %h data %h expected 1 1 00000080 aaaa5555", dmemReq, dmemWe, dmemAddr, dmemWdata); failCount++; end
      assertCount++;
      dmemAck = 1'b1;
      tick();
      dmemAck = 1'b0;
      #1;
      if (memStall !== 1'b0 || wbEnableWb !== 1'b0) begin $display("[TB] FAIL b2b_done: got stall %b wben %b expected 0 0", memStall, wbEnableWb); failCount++; end
      assertCount++;
   endtask

   task automatic test_reset_mid_access();
      applyStimulus(1, 1, 0, 1, 5'd6, 32'h0000_0500, 32'h0, 3'b010);
      tick();
      applyStimulus(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 3'b010);
      if (dmemReq !== 1'b1) begin $display("[TB] FAIL rst_mid_pre: got req %b expected 1", dmemReq); failCount++; end
      assertCount++;
      #2;
      rst = 1'b1;
      #1;
      if (dmemReq !== 1'b0 || memStall !== 1'b0 || dmemAddr !== 32'h0 || wbData !== 32'h0 || wbEnableWb !== 1'b0 || rdWb !== 5'd0) begin
         $display("[TB] FAIL rst_mid_async: got req %b stall %b addr %h wb %h wben %b rd %0d expected all zero", dmemReq, memStall, dmemAddr, wbData, wbEnableWb, rdWb); failCount++; end
      assertCount++;
      tick();
      rst = 1'b0;
      dmemAck = 1'b1;
      dmemRdata = 32'hBADB_ADBA;
      tick();
      dmemAck = 1'b0;
      if (wbData !== 32'h0 || wbEnableWb !== 1'b0 || rdWb !== 5'd0 || dmemReq !== 1'b0) begin
         $display("[TB] FAIL rst_stale_ack: got wb %h wben %b rd %0d req %b expected 0 0 0 0", wbData, wbEnableWb, rdWb, dmemReq); failCount++; end
      assertCount++;
   endtask

`ifdef MEM_SUBWORD_EN
   task automatic test_subword();
      applyStimulus(1, 1, 0, 1, 5'd8, 32'h0000_0103, 32'h0, 3'b000);
      tick();
      applyStimulus(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 3'b010);
      if (dmemAddr !== 32'h100) begin $display("[TB] FAIL lb_addr: got %h expected 00000100", dmemAddr); failCount++; end
      assertCount++;
      dmemAck = 1'b1;
      dmemRdata = 32'h8000_0000;
      tick();
      dmemAck = 1'b0;
      if (wbData !== 32'hFFFF_FF80 || wbEnableWb !== 1'b1) begin
         $display("[TB] FAIL lb_result: got %h %b expected ffffff80 1", wbData, wbEnableWb); failCount++; end
      assertCount++;
      applyStimulus(1, 0, 1, 0, 5'd0, 32'h0000_0101, 32'h0000_BEEF, 3'b001);
      if (memStall !== 1'b1) begin $display("[TB] FAIL sh_mis_stall: got %b expected 1", memStall); failCount++; end
      assertCount++;
      tick();
      applyStimulus(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 3'b010);
      if (memFault !== 1'b1 || dmemReq !== 1'b0 || memStall !== 1'b0 || wbEnableWb !== 1'b0) begin
         $display("[TB] FAIL sh_mis_fault: got fault %b req %b stall %b wben %b expected 1 0 0 0", memFault, dmemReq, memStall, wbEnableWb); failCount++; end
      assertCount++;
      tick();
      if (memFault !== 1'b0 || dmemReq !== 1'b0) begin $display("[TB] FAIL sh_mis_pulse: got fault %b req %b expected 0 0", memFault, dmemReq); failCount++; end
      assertCount++;
   endtask
`else
   task automatic test_word_only();
      applyStimulus(1, 0, 1, 0, 5'd0, 32'h0000_0203, 32'h0BAD_CAFE, 3'b000);
      tick();
      applyStimulus(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 3'b010);
      if (dmemReq !== 1'b1 || dmemAddr !== 32'h200 || dmemWstrb !== 4'hF || dmemWdata !== 32'h0BAD_CAFE || memFault !== 1'b0) begin
         $display("[TB] FAIL word_only_store: got req %b addr %h strb %h data %h fault %b expected 1 00000200 f 0badcafe 0", dmemReq, dmemAddr, dmemWstrb, dmemWdata, memFault); failCount++; end
      assertCount++;
      dmemAck = 1'b1;
      tick();
      dmemAck = 1'b0;
      if (memFault !== 1'b0 || memStall !== 1'b0) begin $display("[TB] FAIL word_only_done: got fault %b stall %b expected 0 0", memFault, memStall); failCount++; end
      assertCount++;
   endtask
`endif

   // Scenario sequence
   initial begin
      test_reset();
      test_alu_passthrough();
      test_load_wait();
      test_store();
      test_timeout();
      test_back_to_back();
      test_reset_mid_access();
`ifdef MEM_SUBWORD_EN
      test_subword();
`else
      test_word_only();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, max cycles waiting for dmem_ack; 0 disables timeout.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 result  in  32  EX/MEM ALU result; byte address for loads/stores, writeback data otherwise.
REQ-005 data_for_writing_for_sw  in  32  store data.
REQ-006 mem_enable_mem, mem_read_mem, mem_write_mem, wb_enable_mem, ld_mem  in  1 each  EX/MEM control.
REQ-007 rd_mem  in  5  destination register.
REQ-008 func  in  3  load/store width code (used only with MEM_SUBWORD_EN).
REQ-009 dmem_req, dmem_we  out  1  memory request / write select.
REQ-010 dmem_addr  out  32  word-aligned address {result[31:2],2'b00}; dmem_wdata out 32; dmem_wstrb out 4.
REQ-011 dmem_ack  in  1; dmem_rdata  in  32  completion and read data, valid with ack.
REQ-012 mem_stall  out  1  freeze/bubble request to upstream stages.
REQ-013 wb_data out 32, rd_wb out 5, wb_enable_wb out 1  MEM/WB pipeline register.
REQ-014 mem_fault  out  1  one-cycle pulse on timeout or misalignment.

Function
REQ-015 States IDLE, ACCESS; reset to IDLE.
REQ-016 IDLE, mem_enable_mem=1 and (mem_read_mem or mem_write_mem)=1 ("start"): capture address, store data, strobes, rd_mem, wb_enable_mem, ld_mem, func into holding registers; go ACCESS.
REQ-017 mem_stall = start or (state==ACCESS), combinational; upstream clearing of EX/MEM during stall cannot corrupt the captured access.
REQ-018 IDLE without start: MEM/WB loads wb_data<=result, rd_wb<=rd_mem, wb_enable_wb<=wb_enable_mem each cycle (1-cycle latency).
REQ-019 ACCESS: dmem_req=1; dmem_we, dmem_addr, dmem_wdata, dmem_wstrb held from holding registers, stable until ack or timeout.
REQ-020 dmem_req=0 and dmem_we=0 in IDLE.
REQ-021 ACCESS with dmem_ack=1: load -> wb_data<=formatted rdata, wb_enable_wb<=captured wb_enable; store -> wb_enable_wb<=0; rd_wb<=captured rd; go IDLE; mem_stall falls next cycle.
REQ-022 Ack in first ACCESS cycle: start cycle + 1 ACCESS cycle stalled, result in MEM/WB at end of that cycle (2-cycle load latency minimum).
REQ-023 While stalled and not completing, wb_enable_wb<=0 (bubble); wb_data, rd_wb hold.
REQ-024 Cycle counter cleared on ACCESS entry, increments per ACCESS cycle without ack; on reaching TIMEOUT_CYCLES without ack: drop req, mem_fault=1 for one cycle, wb_enable_wb<=0, go IDLE.
REQ-025 dmem_ack while IDLE is ignored.
REQ-026 Start condition in the completion cycle is not sampled; next access begins the following IDLE cycle.

Reset
REQ-027 rst=1: state IDLE, counter 0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0, mem_stall=0, wb_data=0, rd_wb=0, wb_enable_wb=0, mem_fault=0, holding registers 0.
REQ-028 Reset during ACCESS aborts immediately; a later dmem_ack for the aborted request is ignored.

Configuration
REQ-029 Macro MEM_SUBWORD_EN defined: func 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; store strobes by result[1:0], data replicated across lanes; loads extract lane and sign/zero-extend.
REQ-030 With MEM_SUBWORD_EN: halfword with result[0]=1 or word with result[1:0]!=0 -> no request, mem_fault pulse, wb_enable_wb<=0, no stall beyond start cycle.
REQ-031 Without MEM_SUBWORD_EN: func ignored, all accesses word, dmem_wstrb=4'hF, result[1:0] ignored, no misalignment fault.

Verification
REQ-032 ALU op result=0x55, rd=7, wb_enable=1, no mem -> next cycle wb_data=0x55, rd_wb=7, wb_enable_wb=1, mem_stall=0 throughout.
REQ-033 Word load addr 0x100, ack after 3 ACCESS cycles with rdata 0xDEADBEEF -> dmem_addr=0x100 stable, mem_stall high 4 cycles, wb_data=0xDEADBEEF, wb_enable_wb=1 one cycle.
REQ-034 Store 0x12345678 to 0x200, immediate ack -> dmem_we=1, wstrb=4'hF, wdata=0x12345678, wb_enable_wb=0.
REQ-035 TIMEOUT_CYCLES=4, load never acked -> req drops after 4 ACCESS cycles, mem_fault single pulse, mem_stall falls, return IDLE.
REQ-036 MEM_SUBWORD_EN: LB addr 0x103, rdata 0x80000000 -> wb_data=0xFFFFFF80; SH addr 0x101 -> mem_fault, no dmem_req.
REQ-037 rst asserted mid-ACCESS, then stale ack -> all outputs reset values, no MEM/WB update.
